// File: rtl/ascii_pkg.sv
// Shared ASCII letter constants for the ascii_reg family of blocks.
// Latency: none (constants only).
// Backpressure: not applicable.
package ascii_pkg;

  localparam logic [7:0] CHAR_A      = 8'h41;
  localparam logic [7:0] CHAR_Z      = 8'h5A;
  localparam logic [7:0] LOWER_A     = 8'h61;
  localparam logic [7:0] LOWER_Z     = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

endpackage

// File: rtl/ascii_fifo_if.sv
// Producer/consumer handshake bundle around the letter FIFO.
// Latency: none (wires only).
// Backpressure: in_ready from the FIFO, out_ready from the consumer.
interface ascii_fifo_if;

  logic [7:0] in_letter;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_letter;
  logic       out_valid;
  logic       out_ready;

  // Driver side: producer of letters and consumer of the head entry.
  modport master (
    output in_letter, in_valid, out_ready,
    input  in_ready, out_letter, out_valid
  );

  // FIFO side.
  modport slave (
    input  in_letter, in_valid, out_ready,
    output in_ready, out_letter, out_valid
  );

endinterface

// File: rtl/ascii_normalise.sv
// Classifies an ASCII byte as a letter and folds lowercase to uppercase.
// Latency: combinational.
// Backpressure: none; pure function of the input byte.
module ascii_normalise
  import ascii_pkg::*;
(
  input  logic [7:0] letter,
  output logic [7:0] upper,
  output logic       is_letter
);

  // Uppercase passes through, lowercase is shifted down, others pass unchanged and flagged.
  always_comb begin
    upper     = letter;
    is_letter = 1'b0;
    if (letter >= CHAR_A && letter <= CHAR_Z) begin
      is_letter = 1'b1;
    end else if (letter >= LOWER_A && letter <= LOWER_Z) begin
      upper     = letter - CASE_OFFSET;
      is_letter = 1'b1;
    end
  end

endmodule

// File: rtl/ascii_fifo.sv
// DEPTH-entry FIFO of uppercase ASCII letters; non-letters are consumed and flagged.
// Latency: 1 cycle from accepted push to out_letter when empty; no bypass paths.
// Backpressure: in_ready = !full (registered state only); pop frees a slot next cycle.
module ascii_fifo
  import ascii_pkg::*;
#(
  parameter int         DEPTH      = 16,
  parameter logic [7:0] RESET_CHAR = 8'h41
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     clear,
  ascii_fifo_if.slave              bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     reject
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [7:0]    upper;
  logic          is_letter;
  logic          take;
  logic          push;
  logic          pop;

  ascii_normalise u_norm (
    .letter    (bus.in_letter),
    .upper     (upper),
    .is_letter (is_letter)
  );

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  assign bus.in_ready   = !full;
  assign bus.out_valid  = !empty;
  // Stale entries stay in mem after a pop, so an empty FIFO must show RESET_CHAR explicitly.
  assign bus.out_letter = empty ? RESET_CHAR : mem[rd_ptr];

  assign take = bus.in_valid && !full;
  assign push = take && is_letter;
  assign pop  = !empty && bus.out_ready;

  // Storage, pointers and occupancy; reset and clear both flush to RESET_CHAR and win over push/pop.
  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_CHAR;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= upper;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // One-cycle pulse after a consumed non-letter offer; clear leaves this path alone.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      reject <= 1'b0;
    end else begin
      reject <= take && !is_letter;
    end
  end

endmodule

// File: tb/tb_ascii_fifo.sv
// Directed bench for ascii_fifo with DEPTH=4.
// Latency: inputs change 1ns after a rising edge, outputs checked at the same point.
// Backpressure: producer holds an offer while in_ready is low.
module tb_ascii_fifo;

  logic       clock;
  logic       resetn;
  logic       clear;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       reject;

  int vectors;
  int miscompares;

  ascii_fifo_if bus ();

  ascii_fifo #(
    .DEPTH      (4),
    .RESET_CHAR (8'h41)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .clear  (clear),
    .bus    (bus.slave),
    .count  (count),
    .full   (full),
    .empty  (empty),
    .reject (reject)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] drain_exp [4];
    vectors       = 0;
    miscompares   = 0;
    resetn        = 1'b0;
    clear         = 1'b0;
    bus.in_letter = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset held for two edges.
    tick();
    tick();
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_out_letter", bus.out_letter, 8'h41);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_reject", reject, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_full", full, 0);
    resetn = 1'b1;
    tick();
    chk("post_rst_count", count, 0);

    // Fold and order: h, E, l -> H, E, L.
    bus.in_valid  = 1'b1;
    bus.in_letter = 8'h68;
    tick();
    chk("fold_first_head", bus.out_letter, 8'h48);
    chk("fold_first_valid", bus.out_valid, 1);
    chk("fold_first_count", count, 1);
    bus.in_letter = 8'h45;
    tick();
    bus.in_letter = 8'h6C;
    tick();
    bus.in_valid = 1'b0;
    chk("fold_count3", count, 3);
    chk("fold_head0", bus.out_letter, 8'h48);
    bus.out_ready = 1'b1;
    tick();
    chk("fold_head1", bus.out_letter, 8'h45);
    chk("fold_count2", count, 2);
    tick();
    chk("fold_head2", bus.out_letter, 8'h4C);
    chk("fold_count1", count, 1);
    tick();
    chk("fold_count0", count, 0);
    chk("fold_empty", empty, 1);
    chk("fold_empty_head", bus.out_letter, 8'h41);
    bus.out_ready = 1'b0;

    // Reject a digit, then a valid lowercase letter is stored.
    bus.in_valid  = 1'b1;
    bus.in_letter = 8'h31;
    tick();
    chk("rej_pulse", reject, 1);
    chk("rej_count", count, 0);
    chk("rej_empty", empty, 1);
    bus.in_letter = 8'h7A;
    tick();
    chk("rej_pulse_end", reject, 0);
    chk("rej_next_count", count, 1);
    chk("rej_next_head", bus.out_letter, 8'h5A);
    // Boundary bytes just outside both letter ranges.
    bus.in_letter = 8'h40;
    tick();
    chk("rej_40", reject, 1);
    bus.in_letter = 8'h5B;
    tick();
    chk("rej_5b", reject, 1);
    bus.in_letter = 8'h60;
    tick();
    chk("rej_60", reject, 1);
    bus.in_letter = 8'h7B;
    tick();
    chk("rej_7b", reject, 1);
    chk("rej_boundary_count", count, 1);
    bus.in_letter = 8'h61;
    tick();
    chk("lower_a_reject", reject, 0);
    chk("lower_a_count", count, 2);
    // Rejected offer together with a pop.
    bus.in_letter = 8'h31;
    bus.out_ready = 1'b1;
    tick();
    chk("rejpop_pulse", reject, 1);
    chk("rejpop_count", count, 1);
    chk("rejpop_head", bus.out_letter, 8'h41);
    bus.in_valid = 1'b0;
    tick();
    chk("rejpop_drain_count", count, 0);
    chk("rejpop_drain_reject", reject, 0);
    bus.out_ready = 1'b0;

    // Full and wrap: A..D fill, E held while full.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_letter = 8'h41 + 8'(i);
      tick();
    end
    bus.in_letter = 8'h45;
    chk("full_flag", full, 1);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_count", count, 4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_hold_count", count, 4);
      chk("full_hold_reject", reject, 0);
      chk("full_hold_head", bus.out_letter, 8'h41);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("full_pop_count", count, 3);
    chk("full_pop_in_ready", bus.in_ready, 1);
    chk("full_pop_head", bus.out_letter, 8'h42);
    bus.out_ready = 1'b0;
    tick();
    chk("full_e_count", count, 4);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain_exp[0] = 8'h42;
    drain_exp[1] = 8'h43;
    drain_exp[2] = 8'h44;
    drain_exp[3] = 8'h45;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_drain", bus.out_letter, drain_exp[i]);
      tick();
    end
    chk("wrap_empty", empty, 1);
    bus.out_ready = 1'b0;

    // Simultaneous push and pop at count 2.
    bus.in_valid  = 1'b1;
    bus.in_letter = 8'h52;
    tick();
    bus.in_letter = 8'h53;
    tick();
    chk("sim_pre_count", count, 2);
    bus.in_letter = 8'h51;
    bus.out_ready = 1'b1;
    tick();
    chk("sim_count", count, 2);
    chk("sim_head", bus.out_letter, 8'h53);
    bus.in_valid = 1'b0;
    tick();
    chk("sim_q_head", bus.out_letter, 8'h51);
    chk("sim_q_count", count, 1);
    tick();
    chk("sim_empty", empty, 1);
    bus.out_ready = 1'b0;

    // Clear with a push in flight.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_letter = 8'h4B + 8'(i);
      tick();
    end
    chk("clr_pre_count", count, 3);
    bus.in_letter = 8'h4E;
    clear = 1'b1;
    tick();
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_count", count, 0);
    chk("clr_head", bus.out_letter, 8'h41);
    chk("clr_empty", empty, 1);
    tick();
    chk("clr_discard_count", count, 0);

    // Reset mid-operation.
    bus.in_valid  = 1'b1;
    bus.in_letter = 8'h58;
    tick();
    chk("mrst_pre_count", count, 1);
    resetn = 1'b0;
    tick();
    resetn       = 1'b1;
    bus.in_valid = 1'b0;
    chk("mrst_count", count, 0);
    chk("mrst_head", bus.out_letter, 8'h41);
    chk("mrst_in_ready", bus.in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ascii_fifo.md
# ascii_fifo

Parametrised, clocked successor to the single-character ASCII register: a DEPTH-entry first-in/first-out buffer of 8-bit ASCII letters with valid/ready handshakes on both sides. Lowercase input is folded to uppercase, and non-letters are rejected. It sits between the keyboard/crib input path and the Bombe/Enigma rotor datapath, so the datapath consumes letters at its own rate.

## Interface
- DEPTH, 16: number of stored letters; power of two, ≥2.
- RESET_CHAR, 8'h41: value presented on out_letter when empty and loaded into every entry at reset/clear ("A").

- clock  input  1  single clock; all state changes on rising edge.
- resetn  input  1  reset, synchronous, active-low.
- clear  input  1  synchronous flush, active-high; same effect as reset except reject is unaffected.
- in_letter  input  8  ASCII character offered by producer.
- in_valid  input  1  producer offers in_letter this cycle.
- in_ready  output  1  = !full; offer consumed when in_valid && in_ready.
- out_letter  output  8  head entry; RESET_CHAR when empty.
- out_valid  output  1  = !empty.
- out_ready  input  1  consumer takes head when out_valid && out_ready.
- count  output  $clog2(DEPTH)+1  number of stored letters, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- reject  output  1  registered one-cycle pulse: previous consumed offer was not a letter.

## Operation
- Accepted offer: 8'h41–8'h5A stored as-is; 8'h61–8'h7A stored minus 8'h20; anything else consumed, not stored, reject=1 next cycle.
- Push: consumed and valid letter → write mem[wr_ptr], wr_ptr+1 (wraps modulo DEPTH), count+1.
- Pop: out_valid && out_ready → rd_ptr+1 (wraps), count−1.
- Simultaneous push and pop (non-empty, non-full): both occur, count unchanged.
- Full: in_ready=0; offer held by producer, no reject, no write. Pop while full frees a slot visible next cycle (no same-cycle pass-through).
- Empty: out_valid=0, out_ready ignored; no bypass of in_letter to out_letter.
- Rejected offer with simultaneous pop: pop proceeds, count−1.
- Reset (resetn=0) or clear=1: wr_ptr=rd_ptr=0, count=0, every mem entry=RESET_CHAR; reset also clears reject. Reset/clear takes priority over any same-cycle push/pop.
- Reset values: in_ready=1, out_valid=0, out_letter=RESET_CHAR, count=0, full=0, empty=1, reject=0.

## Timing
- Push-to-output latency: 1 cycle; letter accepted at edge N is on out_letter with out_valid=1 after edge N when FIFO was empty.
- count, full, empty, in_ready, out_valid are derived from registered state; they update at the edge following the handshake.
- out_letter is a read of mem[rd_ptr] from registered state; no combinational path from in_* to out_*.
- reject is asserted for exactly the cycle after the rejected handshake.
- No combinational path from out_ready to in_ready.

## Structure
- Shared package ascii_pkg: CHAR_A=8'h41, CHAR_Z=8'h5A, LOWER_A=8'h61, LOWER_Z=8'h7A, CASE_OFFSET=8'h20; ascii_reg-family blocks import these.
- Sub-module ascii_normalise: combinational; in letter[7:0] → out upper[7:0], is_letter. It is reused by the crib-entry path.
- Storage is a register array, not inferred RAM, because it needs a reset to RESET_CHAR.

## Test plan
- Reset: hold resetn=0 two cycles, release → empty=1, count=0, out_letter=8'h41, in_ready=1, reject=0.
- Fold and order: push "h","E","l" (8'h68,8'h45,8'h6C), then pop with out_ready=1 → out sequence 8'h48,8'h45,8'h4C; count 3→0.
- Reject: offer 8'h31 ("1") → consumed, reject=1 for one cycle, count unchanged, next valid push stored normally.
- Full/wrap: DEPTH=4, push "A".."D" → full=1, in_ready=0; offer "E" held 3 cycles with no effect; pop one, then "E" accepted; drain → A,B,C,D,E after pointer wrap.
- Simultaneous: count=2, push "Q" and pop same cycle → count stays 2, head advances, "Q" emerges in order.
- Mid-operation reset/clear: count=3 with push in flight, assert clear → next cycle count=0, out_letter=8'h41, pushed letter discarded.
